fifo_sync_flex: RTL

//  Single-clock FIFO, next generation of the team's FIFO family. Supports any depth 2..256
//  (not only powers of two) and a selectable show-ahead (FWFT) or registered-read mode.

---
 rtl/fifo_sync_flex.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_sync_flex.sv
`default_nettype none
// ============================================================================
// fifo_sync_flex : single-clock FIFO, any depth 2..256, FWFT or registered read
// Revision       : 1.0 - initial release
// ============================================================================
module fifo_sync_flex #(
   parameter int FIFODEPTH    = 16,
   parameter int FIFOWIDTH    = 72,
   parameter int FIFOPTRWIDTH = 4,
   parameter bit FWFT         = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wstb,
   input  logic [FIFOWIDTH-1:0]    wdata,
   input  logic                    rstb,
   input  logic [FIFOPTRWIDTH:0]   afull_lvl,
   input  logic [FIFOPTRWIDTH:0]   aempty_lvl,
   input  logic                    clr_err,
   output logic [FIFOWIDTH-1:0]    rdata,
   output logic                    rvalid,
   output logic [FIFOPTRWIDTH:0]   numfilled,
   output logic [FIFOPTRWIDTH:0]   numempty,
   output logic                    full,
   output logic                    empty,
   output logic                    afull,
   output logic                    aempty,
   output logic                    overflow,
   output logic                    underflow
);

   localparam logic [FIFOPTRWIDTH:0]   DEPTH_CNT = (FIFOPTRWIDTH+1)'(FIFODEPTH);
   localparam logic [FIFOPTRWIDTH-1:0] LAST_PTR  = FIFOPTRWIDTH'(FIFODEPTH - 1);

   logic [FIFOWIDTH-1:0]    mem [FIFODEPTH];
   logic [FIFOPTRWIDTH-1:0] wptr;
   logic [FIFOPTRWIDTH-1:0] rptr;
   logic [FIFOPTRWIDTH:0]   count;
   logic                    rd_ok;
   logic                    wr_ok;

   // A full FIFO still takes a write when the same cycle pops a word.
   assign rd_ok = rstb & (count != '0);
   assign wr_ok = wstb & ((count != DEPTH_CNT) | rd_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
         if (rd_ok) rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= wdata;
   end

   // A fresh error outranks a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wstb & ~wr_ok)  overflow <= 1'b1;
         else if (clr_err)   overflow <= 1'b0;
         if (rstb & ~rd_ok)  underflow <= 1'b1;
         else if (clr_err)   underflow <= 1'b0;
      end
   end

   assign numfilled = count;
   assign numempty  = DEPTH_CNT - count;
   assign full      = (count == DEPTH_CNT);
   assign empty     = (count == '0);
   assign afull     = (count >= afull_lvl);
   assign aempty    = (count <= aempty_lvl);

   generate
      if (FWFT) begin : g_fwft
         assign rdata  = mem[rptr];
         assign rvalid = ~empty;
      end else begin : g_regread
         logic [FIFOWIDTH-1:0] rdata_q;
         logic                 rvalid_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= rd_ok;
               if (rd_ok) rdata_q <= mem[rptr];
            end
         end
         assign rdata  = rdata_q;
         assign rvalid = rvalid_q;
      end
   endgenerate

endmodule
`default_nettype wire
